// File: rtl/int_sequencer.sv
// int_sequencer: four-source vectored interrupt controller with a fixed-priority
//   arbiter (source 3 highest). Rising edges on done[] are captured into pending[]
//   and gated by the mask. A single request is raised and the ack/ret handshake runs.
// Ports: clk, rst (sync, active-high); done[3:0] completion lines;
//   mask_we/mask_wd mask write; int_ack/int_ret CPU handshake pulses;
//   int_req, int_id, int_addr = {VEC_BASE, int_id}; pending, mask, busy status.
module int_sequencer #(
  parameter logic [29:0] VEC_BASE = 30'h3FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  done,
  input  logic        mask_we,
  input  logic [3:0]  mask_wd,
  input  logic        int_ack,
  input  logic        int_ret,
  output logic        int_req,
  output logic [1:0]  int_id,
  output logic [31:0] int_addr,
  output logic [3:0]  pending,
  output logic [3:0]  mask,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state;
  logic [3:0] done_q;
  logic [3:0] rise;
  logic [3:0] elig;
  logic [1:0] winner;
  logic [3:0] clr;
  logic       take_ack;

  assign rise = done & ~done_q;
  assign elig = pending & mask;

  // Fixed priority: highest set bit wins.
  always_comb begin
    winner = 2'd0;
    if (elig[3])      winner = 2'd3;
    else if (elig[2]) winner = 2'd2;
    else if (elig[1]) winner = 2'd1;
  end

  // A withdrawn request (nothing eligible) takes precedence over a late ack.
  assign take_ack = (state == REQ) && (elig != 4'b0000) && int_ack;
  assign clr      = take_ack ? (4'b0001 << int_id) : 4'b0000;

  // int_id is a register, so the vector never glitches.
  assign int_addr = {VEC_BASE, int_id};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done_q  <= 4'b0000;
      pending <= 4'b0000;
      mask    <= 4'b0000;
      int_req <= 1'b0;
      int_id  <= 2'd0;
      busy    <= 1'b0;
    end else begin
      done_q  <= done;
      // A new rising edge on the bit being acknowledged survives the clear.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wd;

      case (state)
        IDLE: begin
          int_req <= 1'b0;
          busy    <= 1'b0;
          if (elig != 4'b0000) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= winner;
          end
        end
        REQ: begin
          if (elig == 4'b0000) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else if (int_ack) begin
            state   <= SERVICE;
            int_req <= 1'b0;
            busy    <= 1'b1;
          end else begin
            // Reload every cycle so a higher-priority arrival preempts.
            int_id  <= winner;
          end
        end
        SERVICE: begin
          if (int_ret) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

  localparam logic [29:0] VB = 30'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  done;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        int_ack;
  logic        int_ret;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_addr;
  logic [3:0]  pending;
  logic [3:0]  mask;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_sequencer #(.VEC_BASE(VB)) dut (
    .clk(clk), .rst(rst), .done(done), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_ack(int_ack), .int_ret(int_ret), .int_req(int_req), .int_id(int_id),
    .int_addr(int_addr), .pending(pending), .mask(mask), .busy(busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] done;
    logic       mwe;
    logic [3:0] mwd;
    logic       ack;
    logic       ret;
    logic       e_req;
    logic       e_busy;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] d, logic mwe, logic [3:0] mwd,
                              logic a, logic rt, logic q, logic b, logic [1:0] id,
                              logic [3:0] p, logic [3:0] m);
    vec_t v;
    v.rst = r; v.done = d; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.ret = rt;
    v.e_req = q; v.e_busy = b; v.e_id = id; v.e_pend = p; v.e_mask = m;
    return v;
  endfunction

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [3:0] d, input logic mwe,
                      input logic [3:0] mwd, input logic a, input logic rt);
    rst = r; done = d; mask_we = mwe; mask_wd = mwd; int_ack = a; int_ret = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic q, input logic b,
                       input logic [1:0] id, input logic [3:0] p, input logic [3:0] m);
    logic [43:0] got, exp;
    got = {int_req, busy, int_id, pending, mask, int_addr};
    exp = {q, b, id, p, m, VB, id};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got req=%b busy=%b id=%0d pend=%b mask=%b addr=%h, need req=%b busy=%b id=%0d pend=%b mask=%b addr=%h",
               name, int_req, busy, int_id, pending, mask, int_addr,
               q, b, id, p, m, {VB, id});
    end
  endtask

  // Reference model state (0 idle, 1 requesting, 2 in service).
  int         m_st;
  logic [3:0] m_pend, m_mask, m_dq;
  logic [1:0] m_id;

  function automatic int top_bit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] d, input logic mwe,
                            input logic [3:0] mwd, input logic a, input logic rt);
    logic [3:0] e, nxt_pend;
    int w;
    if (r) begin
      m_st = 0; m_pend = 0; m_mask = 0; m_dq = 0; m_id = 0;
      return;
    end
    e = m_pend & m_mask;
    w = top_bit(e);
    nxt_pend = m_pend;
    if (m_st == 0) begin
      if (w >= 0) begin m_st = 1; m_id = 2'(w); end
    end else if (m_st == 1) begin
      if (w < 0) m_st = 0;
      else if (a) begin m_st = 2; nxt_pend[m_id] = 1'b0; end
      else m_id = 2'(w);
    end else begin
      if (rt) m_st = 0;
    end
    m_pend = nxt_pend | (d & ~m_dq);
    m_dq   = d;
    if (mwe) m_mask = mwd;
  endtask

  initial begin
    rst = 1; done = 0; mask_we = 0; mask_wd = 0; int_ack = 0; int_ret = 0;
    #1;

    //           rst done   mwe mwd    ack ret  req bsy id pend    mask
    // reset
    tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0000, 4'h0));
    tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0000, 4'h0));
    // single source 1
    tbl.push_back(mk(0, 4'h0, 1, 4'hF, 0, 0,  0, 0, 0, 4'b0000, 4'hF));
    tbl.push_back(mk(0, 4'h2, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0010, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  1, 0, 1, 4'b0010, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 1, 1, 4'b0000, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 1, 1, 4'b0000, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 1,  0, 0, 1, 4'b0000, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 1, 4'b0000, 4'hF));
    // simultaneous 0 and 3
    tbl.push_back(mk(0, 4'h9, 0, 4'h0, 0, 0,  0, 0, 1, 4'b1001, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  1, 0, 3, 4'b1001, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 1, 3, 4'b0001, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 1,  0, 0, 3, 4'b0001, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  1, 0, 0, 4'b0001, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 1, 0, 4'b0000, 4'hF));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 1,  0, 0, 0, 4'b0000, 4'hF));
    // masking
    tbl.push_back(mk(0, 4'h0, 1, 4'h1, 0, 0,  0, 0, 0, 4'b0000, 4'h1));
    tbl.push_back(mk(0, 4'h4, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0100, 4'h1));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 0, 4'b0100, 4'h1));
    tbl.push_back(mk(0, 4'h0, 1, 4'h4, 0, 0,  0, 0, 0, 4'b0100, 4'h4));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  1, 0, 2, 4'b0100, 4'h4));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 0, 0,  1, 0, 2, 4'b0100, 4'h0));
    tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 2, 4'b0100, 4'h0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].done, tbl[i].mwe, tbl[i].mwd, tbl[i].ack, tbl[i].ret);
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_busy, tbl[i].e_id,
            tbl[i].e_pend, tbl[i].e_mask);
    end

    // Preemption while requesting: 0 is displaced by 2 before the ack.
    step(1, 4'h0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 1, 4'hF, 0, 0);
    step(0, 4'h1, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 4'h0, 0, 0);
    check("preempt_req0", 1, 0, 0, 4'b0001, 4'hF);
    step(0, 4'h4, 0, 4'h0, 0, 0);
    check("preempt_hold0", 1, 0, 0, 4'b0101, 4'hF);
    step(0, 4'h0, 0, 4'h0, 0, 0);
    check("preempt_id2", 1, 0, 2, 4'b0101, 4'hF);
    step(0, 4'h0, 0, 4'h0, 1, 0);
    check("preempt_ack2", 0, 1, 2, 4'b0001, 4'hF);

    // Events accumulate during service, then a mid-operation reset.
    step(1, 4'h0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 1, 4'hF, 0, 0);
    step(0, 4'h2, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 4'h0, 1, 0);
    check("svc_id1", 0, 1, 1, 4'b0000, 4'hF);
    step(0, 4'h8, 0, 4'h0, 0, 0);
    check("svc_accum", 0, 1, 1, 4'b1000, 4'hF);
    step(0, 4'h0, 0, 4'h0, 0, 0);
    check("svc_noreq", 0, 1, 1, 4'b1000, 4'hF);
    step(1, 4'h0, 0, 4'h0, 0, 0);
    check("midop_rst", 0, 0, 0, 4'b0000, 4'h0);
    step(0, 4'h0, 0, 4'h0, 1, 1);
    check("stray_ackret", 0, 0, 0, 4'b0000, 4'h0);

    // done held high through reset yields exactly one event after release.
    step(1, 4'h1, 0, 4'h0, 0, 0);
    check("held_in_rst", 0, 0, 0, 4'b0000, 4'h0);
    step(0, 4'h1, 1, 4'h0, 0, 0);
    check("held_event", 0, 0, 0, 4'b0001, 4'h0);

    // Randomized run against the reference model.
    model_edge(1, 0, 0, 0, 0, 0);
    step(1, 4'h0, 0, 4'h0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, mwe, a, rt;
      logic [3:0] d, mwd;
      r   = ($urandom_range(0, 149) == 0);
      d   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      mwe = ($urandom_range(0, 9) == 0);
      mwd = 4'($urandom_range(0, 15));
      a   = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      model_edge(r, d, mwe, mwd, a, rt);
      step(r, d, mwe, mwd, a, rt);
      check($sformatf("rand%0d", c), (m_st == 1), (m_st == 2), m_id, m_pend, m_mask);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
